mem_arbiter: RTL

- Shares the single 16-bit SRAM port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each multi-cycle SRAM access with a small FSM, returns read data with a one-cycle ready pulse, and raises stall_req_o to the pipeline control block while any request is outstanding.
- MEM has fixed priority over IF, since it carries the older instruction.

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single SRAM port between instruction fetch and load/store.
// MEM has fixed priority; each access holds the SRAM controls for ACCESS_CYCLES cycles.
module mem_arbiter #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_ready_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ready_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              sram_oe_o,
  output logic              sram_we_o,
  output logic              stall_req_o,
  output logic              state_dbg
);

  typedef enum logic {IDLE, ACC} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       grant, grant_mem, done;
  logic       if_elig, mem_elig;

  // A requester whose ready pulse is high is still holding its old request.
  assign if_elig  = if_req_i  & ~if_ready_o;
  assign mem_elig = mem_req_i & ~mem_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_IF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    grant_mem = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_elig) begin
          grant     = 1'b1;
          grant_mem = 1'b1;
          owner_nxt = OWN_MEM;
          cnt_nxt   = CNT_INIT;
          state_nxt = ACC;
        end else if (if_elig) begin
          grant     = 1'b1;
          owner_nxt = OWN_IF;
          cnt_nxt   = CNT_INIT;
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      sram_oe_o    <= 1'b0;
      sram_we_o    <= 1'b0;
      if_ready_o   <= 1'b0;
      mem_ready_o  <= 1'b0;
      if_inst_o    <= '0;
      mem_rdata_o  <= '0;
    end else begin
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
      if (grant) begin
        if (grant_mem) begin
          sram_addr_o  <= mem_addr_i;
          sram_wdata_o <= mem_wdata_i;
          sram_we_o    <= mem_we_i;
          sram_oe_o    <= ~mem_we_i;
        end else begin
          sram_addr_o <= if_addr_i;
          sram_we_o   <= 1'b0;
          sram_oe_o   <= 1'b1;
        end
      end
      if (done) begin
        sram_oe_o <= 1'b0;
        sram_we_o <= 1'b0;
        if (owner == OWN_MEM) begin
          mem_ready_o <= 1'b1;
          if (!sram_we_o) mem_rdata_o <= sram_rdata_i;
        end else begin
          if_ready_o <= 1'b1;
          if_inst_o  <= sram_rdata_i;
        end
      end
    end
  end

  assign stall_req_o = (if_req_i & ~if_ready_o) | (mem_req_i & ~mem_ready_o);
  assign state_dbg   = (state == ACC);

endmodule
